// File: rtl/pipeline_ctl_pkg.sv
// Shared types and constants for the pipeline flow-control sequencer.
package pipeline_ctl_pkg;

    // Sequencer states: normal flow, transfer in EX, transfer in MEM, front end frozen.
    typedef enum logic [1:0] {
        ST_RUN,
        ST_RESOLVE,
        ST_DRAIN,
        ST_HALT
    } state_e;

    // Class of the control transfer captured when it leaves ID.
    typedef enum logic [1:0] {
        CTL_BR,
        CTL_JAL,
        CTL_JALR
    } ctl_class_e;

    // next_pc_select encodings.
    localparam logic [1:0] NPC_PC4_IF  = 2'd0;  // pc+4 of the IF instruction
    localparam logic [1:0] NPC_PC_IMM  = 2'd1;  // pc+imm of the EX instruction
    localparam logic [1:0] NPC_ALU_TGT = 2'd2;  // alu_result & ~1 (JALR target)
    localparam logic [1:0] NPC_PC4_EX  = 2'd3;  // pc+4 of the EX instruction (branch not taken)

    // Control-transfer opcodes.
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // True when the opcode redirects the program counter.
    function automatic logic is_ctl(input logic [6:0] opcode);
        return (opcode == OPC_BRANCH) || (opcode == OPC_JAL) || (opcode == OPC_JALR);
    endfunction

    // Maps a control-transfer opcode to its class; anything else reads as a branch.
    function automatic ctl_class_e classify(input logic [6:0] opcode);
        ctl_class_e cls;
        cls = CTL_BR;
        if (opcode == OPC_JAL) begin
            cls = CTL_JAL;
        end else if (opcode == OPC_JALR) begin
            cls = CTL_JALR;
        end
        return cls;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: synchronous increment, asynchronous active-low clear, holds at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: step by one unless already at the ceiling.
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + ONE;
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_flow_control.sv
// Flow-control sequencer for the 5-stage pipeline: stalls, control-transfer
// resolution in EX, next-PC selection, debug halt, and stall/flush counters.
module pipeline_flow_control
    import pipeline_ctl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [6:0]           inst_opcode,
    input  logic [2:0]           inst_funct3,
    input  logic                 want_stall,
    input  logic [1:0]           branch_status,
    input  logic                 alu_result_equal_zero,
    input  logic                 halt_request,
    output logic                 pc_write_enable,
    output logic                 no_stall,
    output logic                 inject_bubble,
    output logic                 jump_start,
    output logic [1:0]           next_pc_select,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    state_e     state_q;
    state_e     state_d;
    ctl_class_e class_q;
    logic [2:0] funct3_q;

    logic       branch_taken;
    logic       redirect;
    logic [1:0] resolve_sel;
    logic       stall_inc;
    logic       flush_inc;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture class and funct3 of a transfer as it leaves ID, for use in EX.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            class_q  <= CTL_BR;
            funct3_q <= '0;
        end else if (jump_start) begin
            class_q  <= classify(inst_opcode);
            funct3_q <= inst_funct3;
        end
    end

    // Next-state: halt wins over stall and transfer, and is only looked at in RUN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (halt_request) begin
                    state_d = ST_HALT;
                end else if (!want_stall && is_ctl(inst_opcode)) begin
                    state_d = ST_RESOLVE;
                end
            end
            ST_RESOLVE: state_d = ST_DRAIN;
            ST_DRAIN:   state_d = ST_RUN;
            ST_HALT: begin
                if (!halt_request) begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    // Branch outcome: funct3 bits 0 and 2 together say whether "zero" means taken.
    always_comb begin
        branch_taken = alu_result_equal_zero ^ (funct3_q[0] ^ funct3_q[2]);
        redirect     = (class_q != CTL_BR) || branch_taken;
        unique case (class_q)
            CTL_JAL:  resolve_sel = NPC_PC_IMM;
            CTL_JALR: resolve_sel = NPC_ALU_TGT;
            default:  resolve_sel = branch_taken ? NPC_PC_IMM : NPC_PC4_EX;
        endcase
    end

    // Flow-control outputs; reset forces the frozen/bubble pattern.
    always_comb begin
        pc_write_enable = 1'b0;
        no_stall        = 1'b0;
        inject_bubble   = 1'b1;
        jump_start      = 1'b0;
        next_pc_select  = NPC_PC4_IF;
        halted          = 1'b0;
        if (reset_n) begin
            unique case (state_q)
                ST_RUN: begin
                    if (!halt_request && !want_stall) begin
                        pc_write_enable = 1'b1;
                        no_stall        = 1'b1;
                        inject_bubble   = 1'b0;
                        jump_start      = is_ctl(inst_opcode);
                    end
                end
                ST_RESOLVE: begin
                    pc_write_enable = 1'b1;
                    no_stall        = 1'b1;
                    next_pc_select  = resolve_sel;
                end
                ST_DRAIN: begin
                    pc_write_enable = 1'b1;
                    no_stall        = 1'b1;
                end
                ST_HALT: begin
                    halted = 1'b1;
                end
            endcase
        end
    end

    // Counter increment strobes: hazard stalls only count in RUN without a halt.
    always_comb begin
        stall_inc = (state_q == ST_RUN) && !halt_request && want_stall;
        flush_inc = (state_q == ST_RESOLVE) && redirect;
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .inc_i   (stall_inc),
        .count_o (stall_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .inc_i   (flush_inc),
        .count_o (flush_count)
    );

    // The datapath's view of transfers in EX/MEM must track the sequencer state.
    a_branch_status: assert property (@(posedge clock) disable iff (!reset_n)
        branch_status == {state_q == ST_DRAIN, state_q == ST_RESOLVE});

endmodule

// File: tb/tb_pipeline_flow_control.sv
// Self-checking bench for pipeline_flow_control: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a transfer-age model.
module tb_pipeline_flow_control;

    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_ADD    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic        clock;
    logic        reset_n;
    logic [6:0]  inst_opcode;
    logic [2:0]  inst_funct3;
    logic        want_stall;
    logic [1:0]  branch_status;
    logic        alu_result_equal_zero;
    logic        halt_request;

    logic        pc_write_enable, no_stall, inject_bubble, jump_start, halted;
    logic [1:0]  next_pc_select;
    logic [31:0] stall_count, flush_count;

    logic        pc_write_enable4, no_stall4, inject_bubble4, jump_start4, halted4;
    logic [1:0]  next_pc_select4;
    logic [3:0]  stall_count4, flush_count4;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: age of the in-flight transfer (0 none, 1 in EX, 2 in MEM), halt flag, counts.
    int     m_age = 0;
    bit     m_halted = 0;
    int     m_kind = 0;  // 0 branch, 1 jal, 2 jalr
    bit [2:0] m_f3 = '0;
    longint m_stall = 0;
    longint m_flush = 0;

    pipeline_flow_control #(.CNT_WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n), .inst_opcode(inst_opcode), .inst_funct3(inst_funct3),
        .want_stall(want_stall), .branch_status(branch_status),
        .alu_result_equal_zero(alu_result_equal_zero), .halt_request(halt_request),
        .pc_write_enable(pc_write_enable), .no_stall(no_stall), .inject_bubble(inject_bubble),
        .jump_start(jump_start), .next_pc_select(next_pc_select), .halted(halted),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    pipeline_flow_control #(.CNT_WIDTH(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .inst_opcode(inst_opcode), .inst_funct3(inst_funct3),
        .want_stall(want_stall), .branch_status(branch_status),
        .alu_result_equal_zero(alu_result_equal_zero), .halt_request(halt_request),
        .pc_write_enable(pc_write_enable4), .no_stall(no_stall4), .inject_bubble(inject_bubble4),
        .jump_start(jump_start4), .next_pc_select(next_pc_select4), .halted(halted4),
        .stall_count(stall_count4), .flush_count(flush_count4)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    assign branch_status = {m_age == 2, m_age == 1};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit op_is_ctl(input logic [6:0] op);
        return op == OP_BRANCH || op == OP_JAL || op == OP_JALR;
    endfunction

    // BNE, BLT, BLTU and f3=3 take the branch when the ALU result is non-zero.
    function automatic bit model_redirects();
        bit inverted;
        if (m_kind != 0) return 1'b1;
        inverted = (m_f3 == 3'd1) || (m_f3 == 3'd3) || (m_f3 == 3'd4) || (m_f3 == 3'd6);
        return inverted ? !alu_result_equal_zero : alu_result_equal_zero;
    endfunction

    function automatic longint sat(input longint v, input longint maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // Model update on each clock edge, with asynchronous reset.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_age = 0; m_halted = 0; m_kind = 0; m_f3 = '0; m_stall = 0; m_flush = 0;
        end else if (m_halted) begin
            m_halted = halt_request;
        end else if (m_age == 1) begin
            if (model_redirects()) m_flush++;
            m_age = 2;
        end else if (m_age == 2) begin
            m_age = 0;
        end else if (halt_request) begin
            m_halted = 1'b1;
        end else if (want_stall) begin
            m_stall++;
        end else if (op_is_ctl(inst_opcode)) begin
            m_age  = 1;
            m_kind = (inst_opcode == OP_JAL) ? 1 : (inst_opcode == OP_JALR) ? 2 : 0;
            m_f3   = inst_funct3;
        end
    end

    // Expected outputs for the current cycle.
    task automatic model_out(output logic pcwe, output logic ns, output logic bub,
                             output logic js, output logic [1:0] sel, output logic hl);
        pcwe = 0; ns = 0; bub = 1; js = 0; sel = 2'd0; hl = 0;
        if (reset_n) begin
            if (m_halted) begin
                hl = 1;
            end else if (m_age == 1) begin
                pcwe = 1; ns = 1;
                if (m_kind == 1)      sel = 2'd1;
                else if (m_kind == 2) sel = 2'd2;
                else                  sel = model_redirects() ? 2'd1 : 2'd3;
            end else if (m_age == 2) begin
                pcwe = 1; ns = 1;
            end else if (!halt_request && !want_stall) begin
                pcwe = 1; ns = 1; bub = 0; js = op_is_ctl(inst_opcode);
            end
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        logic e_pcwe, e_ns, e_bub, e_js, e_hl;
        logic [1:0] e_sel;
        model_out(e_pcwe, e_ns, e_bub, e_js, e_sel, e_hl);
        chk("m.pc_write_enable", pc_write_enable, e_pcwe);
        chk("m.no_stall", no_stall, e_ns);
        chk("m.inject_bubble", inject_bubble, e_bub);
        chk("m.jump_start", jump_start, e_js);
        chk("m.next_pc_select", next_pc_select, e_sel);
        chk("m.halted", halted, e_hl);
        chk("m.stall_count", stall_count, sat(m_stall, 64'hFFFF_FFFF));
        chk("m.flush_count", flush_count, sat(m_flush, 64'hFFFF_FFFF));
        chk("m.pc_write_enable4", pc_write_enable4, e_pcwe);
        chk("m.next_pc_select4", next_pc_select4, e_sel);
        chk("m.stall_count4", stall_count4, sat(m_stall, 15));
        chk("m.flush_count4", flush_count4, sat(m_flush, 15));
    end

    // Drive one cycle's inputs just after the rising edge, then wait for the sampling edge.
    task automatic cyc(input logic [6:0] op, input logic [2:0] f3, input logic ws,
                       input logic z, input logic h);
        @(posedge clock);
        #1;
        inst_opcode = op; inst_funct3 = f3; want_stall = ws;
        alu_result_equal_zero = z; halt_request = h;
        @(negedge clock);
    endtask

    initial begin
        bit h;
        int r;
        reset_n = 1'b0; inst_opcode = OP_ADDI; inst_funct3 = '0; want_stall = 1'b0;
        alu_result_equal_zero = 1'b0; halt_request = 1'b0;
        #3;
        chk("rst.pc_we", pc_write_enable, 0);
        chk("rst.bubble", inject_bubble, 1);
        chk("rst.stall_count", stall_count, 0);
        @(negedge clock); #2 reset_n = 1'b1;

        // Straight-line ADDI.
        for (int i = 0; i < 4; i++) begin
            cyc(OP_ADDI, 3'd0, 0, 0, 0);
            chk("addi.pc_we", pc_write_enable, 1);
            chk("addi.no_stall", no_stall, 1);
            chk("addi.bubble", inject_bubble, 0);
            chk("addi.sel", next_pc_select, 0);
        end
        chk("addi.stall_count", stall_count, 0);

        // RAW hazard for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            cyc(OP_ADD, 3'd0, 1, 0, 0);
            chk("raw.pc_we", pc_write_enable, 0);
            chk("raw.bubble", inject_bubble, 1);
        end
        cyc(OP_ADD, 3'd0, 0, 0, 0);
        chk("raw.stall_count", stall_count, 3);

        // BEQ taken.
        cyc(OP_BRANCH, 3'd0, 0, 0, 0);
        chk("beq.jump_start", jump_start, 1);
        cyc(OP_ADDI, 3'd0, 0, 1, 0);
        chk("beq.sel", next_pc_select, 1);
        chk("beq.bubble_ex", inject_bubble, 1);
        cyc(OP_ADDI, 3'd0, 0, 0, 0);
        chk("beq.bubble_mem", inject_bubble, 1);
        cyc(OP_ADDI, 3'd0, 0, 0, 0);
        chk("beq.flush_count", flush_count, 1);

        // BNE with zero set: not taken.
        cyc(OP_BRANCH, 3'd1, 0, 0, 0);
        cyc(OP_ADDI, 3'd0, 0, 1, 0);
        chk("bne.sel", next_pc_select, 3);
        cyc(OP_ADDI, 3'd0, 0, 0, 0);
        cyc(OP_ADDI, 3'd0, 0, 0, 0);
        chk("bne.flush_count", flush_count, 1);

        // BGEU with zero set: taken.
        cyc(OP_BRANCH, 3'd7, 0, 0, 0);
        cyc(OP_ADDI, 3'd0, 0, 1, 0);
        chk("bgeu.sel", next_pc_select, 1);
        cyc(OP_ADDI, 3'd0, 0, 0, 0);
        cyc(OP_ADDI, 3'd0, 0, 0, 0);
        chk("bgeu.flush_count", flush_count, 2);

        // JALR with a hazard raised while it resolves.
        cyc(OP_JALR, 3'd0, 0, 0, 0);
        cyc(OP_ADD, 3'd0, 1, 0, 0);
        chk("jalr.sel", next_pc_select, 2);
        chk("jalr.pc_we", pc_write_enable, 1);
        cyc(OP_ADDI, 3'd0, 0, 0, 0);
        cyc(OP_ADDI, 3'd0, 0, 0, 0);
        chk("jalr.stall_count", stall_count, 3);
        chk("jalr.flush_count", flush_count, 3);

        // Halt requested while a branch resolves: completes, then halts.
        cyc(OP_BRANCH, 3'd0, 0, 0, 0);
        cyc(OP_ADDI, 3'd0, 0, 0, 1);
        chk("halt.resolve_sel", next_pc_select, 3);
        chk("halt.resolve_halted", halted, 0);
        cyc(OP_ADDI, 3'd0, 0, 0, 1);
        chk("halt.drain_pc_we", pc_write_enable, 1);
        cyc(OP_ADDI, 3'd0, 1, 0, 1);
        chk("halt.run_pc_we", pc_write_enable, 0);
        chk("halt.run_halted", halted, 0);
        cyc(OP_ADDI, 3'd0, 1, 0, 1);
        chk("halt.halted", halted, 1);
        cyc(OP_ADDI, 3'd0, 0, 0, 0);
        chk("halt.exit_cycle_halted", halted, 1);
        cyc(OP_ADDI, 3'd0, 0, 0, 0);
        chk("halt.released", halted, 0);
        chk("halt.released_pc_we", pc_write_enable, 1);
        chk("halt.stall_count", stall_count, 3);

        // Reset while a JAL resolves.
        cyc(OP_JAL, 3'd0, 0, 0, 0);
        cyc(OP_ADDI, 3'd0, 0, 0, 0);
        chk("rstmid.sel", next_pc_select, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rstmid.stall_count", stall_count, 0);
        chk("rstmid.flush_count", flush_count, 0);
        chk("rstmid.pc_we", pc_write_enable, 0);
        @(negedge clock); #2 reset_n = 1'b1;
        cyc(OP_ADDI, 3'd0, 0, 0, 0);
        chk("rstmid.run_bubble", inject_bubble, 0);

        // 20 stall cycles: narrow counter saturates.
        for (int i = 0; i < 20; i++) cyc(OP_ADD, 3'd0, 1, 0, 0);
        cyc(OP_ADDI, 3'd0, 0, 0, 0);
        chk("sat.stall_count4", stall_count4, 15);
        chk("sat.stall_count", stall_count, 20);

        // Randomized traffic.
        h = 1'b0;
        for (int i = 0; i < 600; i++) begin
            logic [6:0] op;
            r = int'($urandom_range(0, 5));
            case (r)
                0: op = OP_ADDI;
                1: op = OP_ADD;
                2: op = OP_LOAD;
                3: op = OP_BRANCH;
                4: op = OP_JAL;
                default: op = OP_JALR;
            endcase
            if (h) h = ($urandom_range(0, 9) < 7);
            else   h = ($urandom_range(0, 19) == 0);
            cyc(op, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), h);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
